// File: rtl/alu_pkg.sv
// Shared definitions for the alu popcount accumulator slice: sample width,
// the largest legal popcount, FSM state encoding and a max helper.
package alu_pkg;

  localparam int SUM_W = 4;
  localparam logic [SUM_W-1:0] POP_MAX = 4'd12;

  // FSM state encoding kept as plain constants for legacy-tool friendliness.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_HOLD  = 2'd2;

  function automatic logic [SUM_W-1:0] max_sum(input logic [SUM_W-1:0] a,
                                               input logic [SUM_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_range_chk.sv
// Sample clamp and sticky out-of-range flag. Only instantiated by
// alu_sum_accum when ALU_ACC_RANGE_CHECK_EN is defined.
module alu_range_chk
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SUM_W-1:0] i_sample,
  input  logic             i_accept,
  output logic [SUM_W-1:0] o_sample,
  output logic             o_range_err
);

  logic w_over;
  logic r_range_err;

  assign w_over      = (i_sample > POP_MAX);
  assign o_sample    = w_over ? POP_MAX : i_sample;
  assign o_range_err = r_range_err;

  // Sticky flag: set by any accepted sample above POP_MAX, cleared only by reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!rst_n) begin
      r_range_err <= 1'b0;
    end else if (i_accept && w_over) begin
      r_range_err <= 1'b1;
    end
  end

endmodule

// File: rtl/alu_sum_accum.sv
// Frame accumulator for alu popcount samples: sums FRAME_LEN accepted
// samples, tracks the frame maximum and holds the result until the
// downstream handshake. Optional feature macro: ALU_ACC_RANGE_CHECK_EN
// (clamps samples above POP_MAX and raises a sticky range_err).
module alu_sum_accum
  import alu_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int ACC_W     = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SUM_W-1:0] sum_in,
  input  logic             sum_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [SUM_W-1:0] max_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             range_err
);

  localparam logic [7:0] FRAME_CNT = 8'(FRAME_LEN);

  state_t           r_state;
  logic [7:0]       r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic [SUM_W-1:0] r_max;
  logic [ACC_W-1:0] r_acc_out;
  logic [SUM_W-1:0] r_max_out;
  logic             r_out_valid;

  logic             w_in_ready;
  logic             w_accept;
  logic [SUM_W-1:0] w_sample;
  logic [ACC_W-1:0] w_acc_next;
  logic [SUM_W-1:0] w_max_next;
  logic [7:0]       w_cnt_next;
  logic             w_last;

  assign w_in_ready = (r_state != ST_HOLD);
  assign w_accept   = sum_valid && w_in_ready;

`ifdef ALU_ACC_RANGE_CHECK_EN
  logic w_range_err;

  alu_range_chk u_range_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_sample    (sum_in),
    .i_accept    (w_accept),
    .o_sample    (w_sample),
    .o_range_err (w_range_err)
  );

  assign range_err = w_range_err;
`else
  assign w_sample  = sum_in;
  assign range_err = 1'b0;
`endif

  // Next frame totals for an accept: IDLE starts a fresh frame, ACCUM extends it.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    w_acc_next = ACC_W'(w_sample);
    w_max_next = w_sample;
    w_cnt_next = 8'd1;
    if (r_state == ST_ACCUM) begin
      w_acc_next = r_acc + ACC_W'(w_sample);
      w_max_next = max_sum(r_max, w_sample);
      w_cnt_next = r_cnt + 8'd1;
    end
  end

  assign w_last = (w_cnt_next == FRAME_CNT);

  // Frame FSM plus registered result outputs (zero whenever no frame is held).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 8'd0;
      r_acc       <= '0;
      r_max       <= '0;
      r_acc_out   <= '0;
      r_max_out   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ACCUM: begin
          if (w_accept) begin
            r_acc <= w_acc_next;
            r_max <= w_max_next;
            r_cnt <= w_cnt_next;
            if (w_last) begin
              r_state     <= ST_HOLD;
              r_acc_out   <= w_acc_next;
              r_max_out   <= w_max_next;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ST_ACCUM;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_acc       <= '0;
            r_max       <= '0;
            r_acc_out   <= '0;
            r_max_out   <= '0;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign acc_out   = r_acc_out;
  assign max_out   = r_max_out;
  assign out_valid = r_out_valid;

endmodule
